// File: rtl/hydrophone_peak_scheduler_if.sv
// Stream-in / peak-result-out bundle for hydrophone_peak_scheduler.
// HYDRO_PEAK_INDEX_EN adds the per-channel peak frame index field.
interface hydrophone_peak_scheduler_if
`ifdef HYDRO_PEAK_INDEX_EN
  #(parameter int unsigned IDX_W = 9)
`endif
  ;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        m_result_valid;
  logic        m_result_ready;
  logic [63:0] m_peak;
`ifdef HYDRO_PEAK_INDEX_EN
  logic [4*IDX_W-1:0] m_peak_idx;
`endif

  // Source/consumer side
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_result_ready,
    input  s_axis_tready, m_result_valid, m_peak
`ifdef HYDRO_PEAK_INDEX_EN
    , input m_peak_idx
`endif
  );

  // Scheduler side
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_result_ready,
    output s_axis_tready, m_result_valid, m_peak
`ifdef HYDRO_PEAK_INDEX_EN
    , output m_peak_idx
`endif
  );
endinterface

// File: rtl/hydrophone_peak_scheduler.sv
// Windowed per-channel peak tracker for the 4-channel hydrophone stream.
// Optional HYDRO_PEAK_INDEX_EN keeps the frame index of each channel's first peak.
module hydrophone_peak_scheduler #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned WINDOW_FRAMES        = 500,
  parameter int unsigned IDX_W                = $clog2(WINDOW_FRAMES)
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          run,
  hydrophone_peak_scheduler_if.slave    s,
  output logic                          frame_err
);

  localparam int unsigned      SMP_W      = C_S_AXIS_TDATA_WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(WINDOW_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_t;

  state_t             r_state, w_state_next;
  logic               r_tready, w_tready_next;
  logic               r_result_valid, w_result_valid_next;
  logic               r_phase;
  logic [IDX_W-1:0]   r_count;
  logic [SMP_W-1:0]   r_peak [4];
  logic [SMP_W-1:0]   r_save [2];
  logic [4*SMP_W-1:0] r_res_peak;
  logic               r_frame_err;

  logic [SMP_W-1:0]   w_smp [4];
  logic [SMP_W-1:0]   w_base [4];
  logic [SMP_W-1:0]   w_peak_nxt [4];
  logic               w_upd [4];
  logic               w_hit [4];
  logic               w_accept, w_beat0, w_beat1, w_rollback, w_drop, w_done, w_clear;

`ifdef HYDRO_PEAK_INDEX_EN
  logic [IDX_W-1:0]   r_idx [4];
  logic [IDX_W-1:0]   r_save_idx [2];
  logic [4*IDX_W-1:0] r_res_idx;
  logic [IDX_W-1:0]   w_idx_base [4];
  logic [IDX_W-1:0]   w_idx_nxt [4];
`endif

  // Beat classification; only beats seen in ACCUM with run high count.
  assign w_accept   = (r_state == ST_ACCUM) && run && s.s_axis_tvalid;
  assign w_beat0    = w_accept && !s.s_axis_tlast;
  assign w_rollback = w_beat0 && r_phase;
  assign w_drop     = w_accept && s.s_axis_tlast && !r_phase;
  assign w_beat1    = w_accept && s.s_axis_tlast && r_phase;
  assign w_done     = w_beat1 && (r_count == LAST_FRAME);
  assign w_clear    = (r_state != ST_ACCUM) || !run || w_done;

  // Peak candidates; a broken frame restarts from the pre-frame ch0/ch1 peaks.
  always_comb begin
    w_smp[0]  = s.s_axis_tdata[SMP_W-1:0];
    w_smp[1]  = s.s_axis_tdata[2*SMP_W-1:SMP_W];
    w_smp[2]  = s.s_axis_tdata[SMP_W-1:0];
    w_smp[3]  = s.s_axis_tdata[2*SMP_W-1:SMP_W];
    w_upd[0]  = w_beat0;
    w_upd[1]  = w_beat0;
    w_upd[2]  = w_beat1;
    w_upd[3]  = w_beat1;
    w_base[0] = w_rollback ? r_save[0] : r_peak[0];
    w_base[1] = w_rollback ? r_save[1] : r_peak[1];
    w_base[2] = r_peak[2];
    w_base[3] = r_peak[3];
    for (int i = 0; i < 4; i++) begin
      w_hit[i]      = w_upd[i] && (w_smp[i] > w_base[i]);
      w_peak_nxt[i] = w_hit[i] ? w_smp[i] : w_base[i];
    end
`ifdef HYDRO_PEAK_INDEX_EN
    w_idx_base[0] = w_rollback ? r_save_idx[0] : r_idx[0];
    w_idx_base[1] = w_rollback ? r_save_idx[1] : r_idx[1];
    w_idx_base[2] = r_idx[2];
    w_idx_base[3] = r_idx[3];
    for (int i = 0; i < 4; i++) begin
      w_idx_nxt[i] = w_hit[i] ? r_count : w_idx_base[i];
    end
`endif
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_state        <= ST_IDLE;
      r_tready       <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_tready       <= w_tready_next;
      r_result_valid <= w_result_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (run) w_state_next = ST_ACCUM;
      ST_ACCUM: begin
        if (!run)        w_state_next = ST_IDLE;
        else if (w_done) w_state_next = ST_HOLD;
      end
      ST_HOLD:  if (s.m_result_ready) w_state_next = run ? ST_ACCUM : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    w_tready_next       = (w_state_next != ST_HOLD);
    w_result_valid_next = (w_state_next == ST_HOLD);
  end

  // Window accumulators, result capture and sticky framing error.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      r_phase     <= 1'b0;
      r_count     <= '0;
      r_res_peak  <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < 4; i++) r_peak[i] <= '0;
      for (int i = 0; i < 2; i++) r_save[i] <= '0;
`ifdef HYDRO_PEAK_INDEX_EN
      r_res_idx <= '0;
      for (int i = 0; i < 4; i++) r_idx[i] <= '0;
      for (int i = 0; i < 2; i++) r_save_idx[i] <= '0;
`endif
    end else begin
      if (w_drop || w_rollback) r_frame_err <= 1'b1;
      if (w_done) begin
        r_res_peak <= {w_peak_nxt[3], w_peak_nxt[2], w_peak_nxt[1], w_peak_nxt[0]};
`ifdef HYDRO_PEAK_INDEX_EN
        r_res_idx  <= {w_idx_nxt[3], w_idx_nxt[2], w_idx_nxt[1], w_idx_nxt[0]};
`endif
      end
      if (w_clear) begin
        r_phase <= 1'b0;
        r_count <= '0;
        for (int i = 0; i < 4; i++) r_peak[i] <= '0;
        for (int i = 0; i < 2; i++) r_save[i] <= '0;
`ifdef HYDRO_PEAK_INDEX_EN
        for (int i = 0; i < 4; i++) r_idx[i] <= '0;
        for (int i = 0; i < 2; i++) r_save_idx[i] <= '0;
`endif
      end else begin
        for (int i = 0; i < 4; i++) r_peak[i] <= w_peak_nxt[i];
`ifdef HYDRO_PEAK_INDEX_EN
        for (int i = 0; i < 4; i++) r_idx[i] <= w_idx_nxt[i];
`endif
        if (w_beat0) begin
          r_save[0] <= w_base[0];
          r_save[1] <= w_base[1];
`ifdef HYDRO_PEAK_INDEX_EN
          r_save_idx[0] <= w_idx_base[0];
          r_save_idx[1] <= w_idx_base[1];
`endif
          r_phase <= 1'b1;
        end else if (w_beat1) begin
          r_phase <= 1'b0;
          r_count <= r_count + IDX_W'(1);
        end
      end
    end
  end

  assign s.s_axis_tready  = r_tready;
  assign s.m_result_valid = r_result_valid;
  assign s.m_peak         = r_res_peak;
  assign frame_err        = r_frame_err;
`ifdef HYDRO_PEAK_INDEX_EN
  assign s.m_peak_idx     = r_res_idx;
`endif

endmodule

// File: tb/tb_hydrophone_peak_scheduler.sv
// Scoreboard bench for hydrophone_peak_scheduler (WINDOW_FRAMES=4); checks m_peak_idx
// too when HYDRO_PEAK_INDEX_EN is defined.
module tb_hydrophone_peak_scheduler;

  localparam int unsigned WF = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic run;
  logic frame_err;
  logic man_ready, auto_ready, rnd_ready;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   stuck    = 1'b0;

`ifdef HYDRO_PEAK_INDEX_EN
  hydrophone_peak_scheduler_if #(.IDX_W(IW)) bus ();
`else
  hydrophone_peak_scheduler_if bus ();
`endif

  hydrophone_peak_scheduler #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .WINDOW_FRAMES(WF)
  ) u_dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .run           (run),
    .s             (bus),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);
  assign bus.m_result_ready = auto_ready ? rnd_ready : man_ready;

  typedef struct packed {
    logic [63:0]      peak;
    logic [4*IW-1:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] win_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a window is the list of good frames; peak = max, idx = first frame holding it.
  function automatic void model_frame(input logic [63:0] f);
    exp_t        e;
    logic [15:0] best, v;
    int          bi;
    win_q.push_back(f);
    if (win_q.size() == WF) begin
      e = '0;
      for (int ch = 0; ch < 4; ch++) begin
        best = 16'd0;
        bi   = 0;
        for (int k = 0; k < WF; k++) begin
          v = win_q[k][16*ch +: 16];
          if (v > best) begin
            best = v;
            bi   = k;
          end
        end
        e.peak[16*ch +: 16] = best;
        e.idx[IW*ch +: IW]  = IW'(bi);
      end
      exp_q.push_back(e);
      win_q.delete();
    end
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [31:0] d, input logic last);
    int waitc = 0;
    if (stuck) return;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    while (!bus.s_axis_tready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_timeout: tready still %b after %0d cycles, required 1", bus.s_axis_tready, waitc);
        stuck = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] c0, c1, c2, c3);
    send_beat({c1, c0}, 1'b0);
    send_beat({c3, c2}, 1'b1);
    model_frame({c3, c2, c1, c0});
  endtask

  function automatic logic [15:0] rnd_smp();
    case ($urandom_range(0, 3))
      0:       rnd_smp = 16'hFFFF;
      1:       rnd_smp = 16'($urandom_range(0, 7) * 8192);
      default: rnd_smp = 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic drain(input string name);
    int waitc = 0;
    while (exp_q.size() != 0 && waitc < 500) begin
      @(negedge clk);
      waitc++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT's result is being accepted.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && bus.m_result_valid && bus.m_result_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got peak %h, required no result", bus.m_peak);
      end else begin
        e = exp_q.pop_front();
        check("result_peak", bus.m_peak, e.peak);
`ifdef HYDRO_PEAK_INDEX_EN
        check("result_idx", 64'(bus.m_peak_idx), 64'(e.idx));
`endif
        check("hold_tready", 64'(bus.s_axis_tready), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0; run = 1'b0; man_ready = 1'b0; auto_ready = 1'b0;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tready", 64'(bus.s_axis_tready), 64'd0);
    check("reset_valid", 64'(bus.m_result_valid), 64'd0);
    check("reset_peak", bus.m_peak, 64'd0);
    check("reset_err", 64'(frame_err), 64'd0);
`ifdef HYDRO_PEAK_INDEX_EN
    check("reset_idx", 64'(bus.m_peak_idx), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tready", 64'(bus.s_axis_tready), 64'd1);
    run = 1'b1;
    @(negedge clk);

    // Directed window: continuous beats, held result
    t0 = cyc;
    send_frame(16'd10, 16'd20, 16'd30, 16'd40);
    send_frame(16'd50, 16'd5,  16'd5,  16'd5);
    send_frame(16'd50, 16'd60, 16'd1,  16'd1);
    send_frame(16'd0,  16'd0,  16'd0,  16'd90);
    check("b2b_cycles", 64'(cyc - t0), 64'd8);
    check("valid_latency", 64'(bus.m_result_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.m_result_valid), 64'd1);
      check("hold_peak", bus.m_peak, 64'h005A_001E_003C_0032);
      check("hold_stall", 64'(bus.s_axis_tready), 64'd0);
`ifdef HYDRO_PEAK_INDEX_EN
      check("hold_idx", 64'(bus.m_peak_idx), 64'hC9);
`endif
    end
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    check("post_accept_tready", 64'(bus.s_axis_tready), 64'd1);
    check("post_accept_valid", 64'(bus.m_result_valid), 64'd0);

    // Next window must start from zero peaks
    auto_ready = 1'b1;
    send_frame(16'd1, 16'd2, 16'd3, 16'd4);
    send_frame(16'd0, 16'd0, 16'd0, 16'd0);
    send_frame(16'd2, 16'd1, 16'd0, 16'd0);
    send_frame(16'd0, 16'd0, 16'd5, 16'd0);
    check("err_clear", 64'(frame_err), 64'd0);

    // Stray frame-end beat at phase 0
    send_frame(16'd100, 16'd200, 16'd300, 16'd400);
    send_beat(32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    check("err_set", 64'(frame_err), 64'd1);
    send_frame(16'd7, 16'd700, 16'd3, 16'd4);
    send_frame(16'd9, 16'd8, 16'd301, 16'd2);
    send_frame(16'd1, 16'd1, 16'd1, 16'd401);

    // Orphan beat 0 followed by a fresh beat 0 rolls back
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_frame(16'd11, 16'd12, 16'd13, 16'd14);
    send_frame(16'd21, 16'd2, 16'd23, 16'd4);
    send_frame(16'd1, 16'd32, 16'd3, 16'd34);
    send_frame(16'd5, 16'd5, 16'd5, 16'd5);

    // Ties keep the earliest frame
    send_frame(16'd1, 16'h8000, 16'd0, 16'd0);
    send_frame(16'd2, 16'd3, 16'd4, 16'd5);
    send_frame(16'd0, 16'h8000, 16'd0, 16'd0);
    send_frame(16'd0, 16'd1, 16'd2, 16'd3);

    // Abort after two frames
    send_frame(16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3);
    send_frame(16'hFFF4, 16'hFFF5, 16'hFFF6, 16'hFFF7);
    run = 1'b0;
    win_q.delete();
    repeat (3) @(negedge clk);
    drain("abort_drain");
    check("abort_no_result", 64'(bus.m_result_valid), 64'd0);
    check("abort_idle_tready", 64'(bus.s_axis_tready), 64'd1);
    run = 1'b1;
    @(negedge clk);
    send_frame(16'd3, 16'd3, 16'd3, 16'd3);
    send_frame(16'd4, 16'd2, 16'd4, 16'd2);
    send_frame(16'd1, 16'd9, 16'd1, 16'd9);
    send_frame(16'd8, 16'd8, 16'd8, 16'd8);

    // Randomized windows with occasional framing glitches
    for (int w = 0; w < 15; w++) begin
      for (int f = 0; f < WF; f++) begin
        case ($urandom_range(0, 7))
          0: send_beat($urandom, 1'b1);
          1: send_beat($urandom, 1'b0);
          default: ;
        endcase
        send_frame(rnd_smp(), rnd_smp(), rnd_smp(), rnd_smp());
      end
    end
    drain("random_drain");

    // Reset while a result is held
    auto_ready = 1'b0;
    man_ready  = 1'b0;
    send_frame(16'd5, 16'd6, 16'd7, 16'd8);
    send_frame(16'd1, 16'd1, 16'd1, 16'd1);
    send_frame(16'd2, 16'd2, 16'd2, 16'd2);
    send_frame(16'd3, 16'd3, 16'd3, 16'd3);
    check("rst_hold_valid", 64'(bus.m_result_valid), 64'd1);
    if (exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 64'(bus.m_result_valid), 64'd0);
    check("rst_err", 64'(frame_err), 64'd0);
    check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_peak", bus.m_peak, 64'd0);
    @(negedge clk);
    check("rst_release_tready", 64'(bus.s_axis_tready), 64'd1);
    run = 1'b0;
    auto_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
